// File: rtl/pe_pkg.sv
// Shared types and constants for the systolic matrix-multiply processing element.
package pe_pkg;

   localparam int DATA_W = 32;

   typedef enum logic {
      LOAD    = 1'b0,
      COMPUTE = 1'b1
   } phase_e;

   // One beat travelling down the chain: both data words plus their valid flags.
   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              stb;
      logic              b_valid;
   } beat_t;

   function automatic int pe_n(input int log_size);
      return 1 << log_size;
   endfunction

endpackage

// File: rtl/pe_fwd_stage.sv
// Single backpressured register stage that forwards a beat to the next PE.
module pe_fwd_stage
   import pe_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  beat_t i_beat,
   input  logic  i_next_ack,
   output beat_t o_beat,
   output logic  o_ack,
   output logic  o_accept
);

   beat_t r_beat;
   logic  w_full;

   assign w_full   = r_beat.stb | r_beat.b_valid;
   assign o_ack    = !w_full | i_next_ack;
   assign o_accept = (i_beat.stb | i_beat.b_valid) & o_ack;
   assign o_beat   = r_beat;

   // Data words are left stale on drain; only the flags mark the stage empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_beat <= '0;
      end else if (o_accept) begin
         r_beat <= i_beat;
      end else if (i_next_ack & w_full) begin
         r_beat.stb     <= 1'b0;
         r_beat.b_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pe.sv
// Systolic PE: loads column index-1 of B, then multiply-accumulates rows of A.
// Optional result memory enabled by defining PE_RESULT_MEM_EN.
module pe
   import pe_pkg::*;
#(
   parameter int log_size = 2,
   parameter int index    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              stb,
   input  logic              input_b_valid,
   output logic              input_ack,
   input  logic              next_PE_ack,
   output logic [DATA_W-1:0] output_a,
   output logic [DATA_W-1:0] output_b,
   output logic              output_stb,
   output logic              output_b_valid,
`ifdef PE_RESULT_MEM_EN
   input  logic [log_size-1:0] addr,
   input  logic                mem_select,
`endif
   output logic [DATA_W-1:0] c
);

   localparam int                N    = pe_n(log_size);
   localparam logic [log_size-1:0] COL  = log_size'(index - 1);
   localparam logic [log_size-1:0] LAST = '1;

   beat_t  w_in_beat;
   beat_t  w_out_beat;
   logic   w_accept;

   assign w_in_beat = '{a: a, b: b, stb: stb, b_valid: input_b_valid};

   pe_fwd_stage u_fwd (
      .clk        (clk),
      .rst        (rst),
      .i_beat     (w_in_beat),
      .i_next_ack (next_PE_ack),
      .o_beat     (w_out_beat),
      .o_ack      (input_ack),
      .o_accept   (w_accept)
   );

   assign output_a       = w_out_beat.a;
   assign output_b       = w_out_beat.b;
   assign output_stb     = w_out_beat.stb;
   assign output_b_valid = w_out_beat.b_valid;

   phase_e                  r_phase;
   logic [2*log_size-1:0]   r_cnt;
   logic [DATA_W-1:0]       r_bmem [N];
   logic [DATA_W-1:0]       r_acc;
   logic [DATA_W-1:0]       r_c;

   logic [log_size-1:0]     w_m;
   logic [log_size-1:0]     w_j;
   logic [DATA_W-1:0]       w_prod;
   logic [DATA_W-1:0]       w_sum;
   logic                    w_load_beat;
   logic                    w_mac_beat;
   logic                    w_row_done;

   // Row m and column j packed into one counter so j wraps straight into m.
   assign w_m         = r_cnt[2*log_size-1:log_size];
   assign w_j         = r_cnt[log_size-1:0];
   assign w_prod      = a * r_bmem[w_j];
   assign w_sum       = r_acc + w_prod;
   assign w_load_beat = (r_phase == LOAD) & w_accept & input_b_valid;
   assign w_mac_beat  = (r_phase == COMPUTE) & w_accept & stb;
   assign w_row_done  = w_mac_beat & (w_j == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_phase <= LOAD;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_c     <= '0;
         for (int i = 0; i < N; i++) r_bmem[i] <= '0;
      end else begin
         case (r_phase)
            LOAD: begin
               if (w_load_beat) begin
                  if (w_j == COL) r_bmem[w_m] <= b;
                  r_cnt <= r_cnt + 1'b1;
                  if (&r_cnt) r_phase <= COMPUTE;
               end
            end
            COMPUTE: begin
               if (w_mac_beat) begin
                  if (w_j == LAST) begin
                     r_c   <= w_sum;
                     r_acc <= '0;
                  end else begin
                     r_acc <= w_sum;
                  end
                  r_cnt <= r_cnt + 1'b1;
                  if (&r_cnt) r_phase <= LOAD;
               end
            end
            default: r_phase <= LOAD;
         endcase
      end
   end

`ifdef PE_RESULT_MEM_EN
   logic [DATA_W-1:0] r_cmem [N];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) r_cmem[i] <= '0;
      end else if (w_row_done) begin
         r_cmem[w_m] <= w_sum;
      end
   end

   assign c = mem_select ? r_cmem[addr] : r_c;
`else
   assign c = r_c;
`endif

endmodule

// File: tb/tb_pe.sv
// Self-checking bench for pe (log_size=2, index=2): forward scoreboard plus result queue.
module tb_pe;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a, b;
   logic        stb, input_b_valid, next_PE_ack;
   logic        input_ack;
   logic [31:0] output_a, output_b, c;
   logic        output_stb, output_b_valid;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        stb;
      logic        bv;
   } fwd_t;

   fwd_t        fq[$];
   logic [31:0] c_q[$];
   logic [31:0] tb_b[16];
   logic [31:0] c_last;

   always #5 clk = ~clk;

   pe #(.log_size(2), .index(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .a              (a),
      .b              (b),
      .stb            (stb),
      .input_b_valid  (input_b_valid),
      .input_ack      (input_ack),
      .next_PE_ack    (next_PE_ack),
      .output_a       (output_a),
      .output_b       (output_b),
      .output_stb     (output_stb),
      .output_b_valid (output_b_valid),
      .c              (c)
   );

   // Forward scoreboard: push on accept, pop on drain; inputs change only at posedge+1.
   always @(negedge clk) begin
      if (!rst) begin
         fq.delete();
      end else begin
         if ((output_stb | output_b_valid) && next_PE_ack) begin
            checks++;
            if (fq.size() == 0) begin
               errors++;
               $display("FAIL fwd_extra: got a=%h b=%h stb=%b bv=%b, required no beat",
                        output_a, output_b, output_stb, output_b_valid);
            end else begin
               fwd_t e;
               e = fq.pop_front();
               if ({output_a, output_b, output_stb, output_b_valid} !== {e.a, e.b, e.stb, e.bv}) begin
                  errors++;
                  $display("FAIL fwd_data: got a=%h b=%h stb=%b bv=%b, required a=%h b=%h stb=%b bv=%b",
                           output_a, output_b, output_stb, output_b_valid, e.a, e.b, e.stb, e.bv);
               end
            end
         end
         if ((stb | input_b_valid) && input_ack)
            fq.push_back('{a: a, b: b, stb: stb, bv: input_b_valid});
      end
   end

   task automatic send_beat(input logic [31:0] av, input logic [31:0] bv_, input logic s, input logic v);
      int n;
      a = av; b = bv_; stb = s; input_b_valid = v;
      n = 0;
      @(negedge clk);
      while (!input_ack && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!input_ack) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: input_ack=%b, required 1 within 50 cycles", input_ack);
      end
      @(posedge clk); #1;
      stb = 1'b0; input_b_valid = 1'b0;
   endtask

   // mode 0: values 1..16, mode 1: all ones, mode 2: all twos
   task automatic load_b(input int mode);
      for (int k = 0; k < 16; k++) begin
         tb_b[k] = (mode == 0) ? 32'(k + 1) : (mode == 1) ? 32'd1 : 32'd2;
         send_beat(32'hA0 + 32'(k), tb_b[k], 1'b0, 1'b1);
      end
   endtask

   task automatic send_row(input logic [31:0] r0, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] r3);
      logic [31:0] r[4];
      logic [31:0] exp;
      r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3;
      exp = '0;
      for (int k = 0; k < 4; k++) exp = exp + r[k] * tb_b[k*4 + 1];
      c_q.push_back(exp);
      for (int k = 0; k < 4; k++) begin
         send_beat(r[k], 32'hB0 + 32'(k), 1'b1, 1'b0);
         checks++;
         if (k < 3) begin
            if (c !== c_last) begin
               errors++;
               $display("FAIL c_hold: got %h, required %h", c, c_last);
            end
         end else begin
            c_last = c_q.pop_front();
            if (c !== c_last) begin
               errors++;
               $display("FAIL c_result: got %h, required %h", c, c_last);
            end
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0; a = '0; b = '0; stb = 1'b0; input_b_valid = 1'b0; next_PE_ack = 1'b1;
      c_last = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({output_stb, output_b_valid, input_ack, c, output_a, output_b} !== {1'b0, 1'b0, 1'b1, 96'h0}) begin
         errors++;
         $display("FAIL reset_state: stb=%b bv=%b ack=%b c=%h oa=%h ob=%h, required 0 0 1 0 0 0",
                  output_stb, output_b_valid, input_ack, c, output_a, output_b);
      end
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_forward;
      send_beat(32'h11, 32'h22, 1'b1, 1'b1);
      checks++;
      if ({output_a, output_b, output_stb, output_b_valid} !== {32'h11, 32'h22, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL fwd_beat: got a=%h b=%h stb=%b bv=%b, required 11 22 1 1",
                  output_a, output_b, output_stb, output_b_valid);
      end
      @(posedge clk); #1;
      checks++;
      if ({output_stb, output_b_valid} !== 2'b00) begin
         errors++;
         $display("FAIL fwd_empty: got stb=%b bv=%b, required 0 0", output_stb, output_b_valid);
      end
      // The combined beat consumed one b slot; start the next test from a clean LOAD.
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_load_compute;
      load_b(0);
      send_row(32'd1, 32'd1, 32'd1, 32'd1);
      send_row(32'd1, 32'd2, 32'd3, 32'd4);
      send_row(32'd5, 32'd0, 32'd7, 32'd3);
      send_row(32'd9, 32'd8, 32'd1, 32'd2);
   endtask

   task automatic test_phase_return;
      load_b(1);
      send_row(32'd1, 32'd2, 32'd3, 32'd4);
      send_row(32'd0, 32'd0, 32'd0, 32'd0);
      send_row(32'd7, 32'd7, 32'd7, 32'd7);
      send_row(32'd3, 32'd1, 32'd4, 32'd1);
   endtask

   task automatic test_wrap;
      load_b(2);
      send_row(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      checks++;
      if (c !== 32'hFFFF_FFF8) begin
         errors++;
         $display("FAIL wrap_const: got %h, required fffffff8", c);
      end
      send_row(32'h8000_0000, 32'h8000_0000, 32'd1, 32'd1);
      send_row(32'd1, 32'd1, 32'd1, 32'd1);
      send_row(32'd2, 32'd2, 32'd2, 32'd2);
   endtask

   task automatic test_backpressure;
      logic [31:0] held_a;
      load_b(0);
      c_q.push_back(32'd32);
      send_beat(32'd1, 32'hC0, 1'b1, 1'b0);
      send_beat(32'd1, 32'hC1, 1'b1, 1'b0);
      next_PE_ack = 1'b0;
      a = 32'd1; b = 32'hC2; stb = 1'b1;
      held_a = output_a;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if ({input_ack, output_a, output_stb, c} !== {1'b0, held_a, 1'b1, c_last}) begin
            errors++;
            $display("FAIL bp_stall: ack=%b oa=%h stb=%b c=%h, required 0 %h 1 %h",
                     input_ack, output_a, output_stb, c, held_a, c_last);
         end
      end
      @(posedge clk); #1;
      next_PE_ack = 1'b1;
      send_beat(32'd1, 32'hC2, 1'b1, 1'b0);
      send_beat(32'd1, 32'hC3, 1'b1, 1'b0);
      c_last = c_q.pop_front();
      checks++;
      if (c !== c_last) begin
         errors++;
         $display("FAIL bp_result: got %h, required %h", c, c_last);
      end
      send_beat(32'd1, 32'hC4, 1'b1, 1'b0);
      send_beat(32'd1, 32'hC5, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid;
      rst = 1'b0;
      #1;
      checks++;
      if ({c, output_stb, output_b_valid, input_ack} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL mid_reset: c=%h stb=%b bv=%b ack=%b, required 0 0 0 1",
                  c, output_stb, output_b_valid, input_ack);
      end
      c_last = '0;
      c_q.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      load_b(0);
      send_row(32'd1, 32'd1, 32'd1, 32'd1);
      checks++;
      if (c !== 32'd32) begin
         errors++;
         $display("FAIL mid_reset_reload: got %h, required 00000020", c);
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_load_compute();
      test_phase_return();
      test_wrap();
      test_backpressure();
      test_reset_mid();
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
